// File: rtl/mem_test_engine_pkg.sv
// Shared opcodes, FSM states and constants for the memory test engine.
// Imported by the engine top; no ports.
package mem_test_engine_pkg;

    localparam logic [7:0]  OP_READ      = 8'h01;
    localparam logic [7:0]  OP_FILL      = 8'h02;
    localparam logic [7:0]  OP_CHECK     = 8'h03;
    localparam logic [15:0] NO_FAIL_ADDR = 16'hFFFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_TX,
        S_WR,
        S_CMP,
        S_RESULT,
        S_DRAIN
    } state_t;

    function automatic logic is_op(input logic [7:0] b);
        return (b == OP_READ) || (b == OP_FILL) || (b == OP_CHECK);
    endfunction

endpackage

// File: rtl/mem_test_engine_if.sv
// SPI byte handshakes plus banked RAM bus of the memory test engine.
// master: engine side; slave: SPI slave + memory side.
interface mem_test_engine_if #(
    parameter int NUM_BANKS   = 20,
    parameter int BANK_ADDR_W = 9
);
    logic                   spi_cs_n;
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic                   tx_valid;
    logic [7:0]             tx_byte;
    logic                   tx_ready;
    logic [NUM_BANKS-1:0]   mem_cs;
    logic [BANK_ADDR_W-1:0] mem_addr;
    logic                   mem_we;
    logic [7:0]             mem_wdata;
    logic [7:0]             mem_rdata;

    modport master (
        input  spi_cs_n, rx_valid, rx_byte, tx_ready, mem_rdata,
        output tx_valid, tx_byte, mem_cs, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output spi_cs_n, rx_valid, rx_byte, tx_ready, mem_rdata,
        input  tx_valid, tx_byte, mem_cs, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_bank_decode.sv
// Splits a global address into one-hot bank select, in-bank offset
// and an in_range flag. Ports: addr in; cs, offset, in_range out.
module mem_bank_decode #(
    parameter int NUM_BANKS   = 20,
    parameter int BANK_ADDR_W = 9,
    parameter int ADDR_W      = 16
) (
    input  logic [ADDR_W-1:0]      addr,
    output logic [NUM_BANKS-1:0]   cs,
    output logic [BANK_ADDR_W-1:0] offset,
    output logic                   in_range
);
    localparam int BANK_W = ADDR_W - BANK_ADDR_W;

    logic [BANK_W-1:0] bank;

    assign bank     = addr[ADDR_W-1:BANK_ADDR_W];
    assign offset   = addr[BANK_ADDR_W-1:0];
    assign in_range = int'(bank) < NUM_BANKS;

    // Banks past NUM_BANKS match no bit, so cs stays all-zero.
    always_comb begin
        cs = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            cs[i] = (int'(bank) == i);
    end
endmodule

// File: rtl/mem_test_engine.sv
// SPI command engine: burst READ, pattern FILL and CHECK on banked RAM.
// Ports: i_clk, i_rst_n, o_busy, bus (master). Option: MEM_TEST_FIRST_FAIL_ADDR_EN.
module mem_test_engine
    import mem_test_engine_pkg::*;
#(
    parameter int NUM_BANKS   = 20,
    parameter int BANK_ADDR_W = 9,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_busy,
    mem_test_engine_if.master bus
);
    if (DATA_W != 8) begin : g_bad_data_w
        $error("mem_test_engine: DATA_W must be 8");
    end

`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
    localparam logic [1:0] RES_LAST = 2'd3;
    logic [15:0] fail_addr;
`else
    localparam logic [1:0] RES_LAST = 2'd1;
`endif

    state_t                 state, nxt;
    logic [7:0]             op, pat, data, res_byte;
    logic [1:0]             hdr_idx, res_idx;
    logic [ADDR_W-1:0]      addr;
    logic [8:0]             cnt, err_cnt;
    logic                   access, write, tx_fire;
    logic [NUM_BANKS-1:0]   dec_cs;
    logic [BANK_ADDR_W-1:0] dec_off;
    logic                   dec_in;

    mem_bank_decode #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_ADDR_W(BANK_ADDR_W),
        .ADDR_W     (ADDR_W)
    ) u_dec (
        .addr    (addr),
        .cs      (dec_cs),
        .offset  (dec_off),
        .in_range(dec_in)
    );

    assign tx_fire = bus.tx_valid && bus.tx_ready;

    // cnt holds accesses still to issue; it drops on every access.
    always_comb begin
        nxt    = state;
        access = 1'b0;
        write  = 1'b0;
        case (state)
            S_IDLE:
                if (bus.rx_valid)
                    nxt = is_op(bus.rx_byte) ? S_HDR : S_DRAIN;
            S_HDR:
                if (bus.rx_valid) begin
                    if (hdr_idx == 2'd2 && op == OP_READ)
                        nxt = S_RD_ISSUE;
                    else if (hdr_idx == 2'd3)
                        nxt = (op == OP_FILL) ? S_WR : S_RD_ISSUE;
                end
            S_RD_ISSUE: begin
                access = 1'b1;
                nxt    = S_RD_WAIT;
            end
            S_RD_WAIT:
                nxt = (op == OP_READ) ? S_TX : S_CMP;
            S_TX:
                if (tx_fire)
                    nxt = (cnt == 9'd0) ? S_DRAIN : S_RD_ISSUE;
            S_WR: begin
                access = 1'b1;
                write  = 1'b1;
                if (cnt == 9'd1)
                    nxt = S_DRAIN;
            end
            // Compares the byte just captured while issuing the next read,
            // keeping CHECK at one byte per two cycles.
            S_CMP:
                if (cnt == 9'd0) begin
                    nxt = S_RESULT;
                end else begin
                    access = 1'b1;
                    nxt    = S_RD_WAIT;
                end
            S_RESULT:
                if (tx_fire && res_idx == RES_LAST)
                    nxt = S_DRAIN;
            S_DRAIN: ;
            default: nxt = S_IDLE;
        endcase
        if (bus.spi_cs_n) begin
            nxt    = S_IDLE;
            access = 1'b0;
            write  = 1'b0;
        end
    end

    always_comb begin
        res_byte = 8'h00;
        case (res_idx)
            2'd0: res_byte = {7'b0, err_cnt[8]};
            2'd1: res_byte = err_cnt[7:0];
`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
            2'd2: res_byte = fail_addr[15:8];
            2'd3: res_byte = fail_addr[7:0];
`endif
            default: res_byte = 8'h00;
        endcase
    end

    assign bus.mem_cs    = access ? dec_cs : '0;
    assign bus.mem_addr  = access ? dec_off : '0;
    assign bus.mem_we    = write;
    assign bus.mem_wdata = write ? pat : 8'h00;
    assign bus.tx_valid  = (state == S_TX) || (state == S_RESULT);
    assign bus.tx_byte   = (state == S_TX)     ? data :
                           (state == S_RESULT) ? res_byte : 8'h00;
    assign o_busy        = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            op      <= 8'h00;
            pat     <= 8'h00;
            data    <= 8'h00;
            hdr_idx <= 2'd0;
            res_idx <= 2'd0;
            addr    <= '0;
            cnt     <= 9'd0;
            err_cnt <= 9'd0;
`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
            fail_addr <= NO_FAIL_ADDR;
`endif
        end else begin
            state <= nxt;
            if (access)
                cnt <= cnt - 9'd1;
            if (write || state == S_RD_WAIT)
                addr <= addr + ADDR_W'(1);
            case (state)
                S_IDLE:
                    if (bus.rx_valid) begin
                        op      <= bus.rx_byte;
                        hdr_idx <= 2'd0;
                        res_idx <= 2'd0;
                        err_cnt <= 9'd0;
`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
                        fail_addr <= NO_FAIL_ADDR;
`endif
                    end
                S_HDR:
                    if (bus.rx_valid) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: addr <= ADDR_W'(bus.rx_byte);
                            2'd1: addr <= ADDR_W'({addr[7:0], bus.rx_byte});
                            2'd2: cnt  <= {1'b0, bus.rx_byte} + 9'd1;
                            default: pat <= bus.rx_byte;
                        endcase
                    end
                S_RD_WAIT:
                    data <= dec_in ? bus.mem_rdata : 8'h00;
                S_CMP:
                    if (data != pat) begin
                        err_cnt <= err_cnt + 9'd1;
`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
                        // addr already stepped past the compared byte
                        if (err_cnt == 9'd0)
                            fail_addr <= 16'(addr - ADDR_W'(1));
`endif
                    end
                S_RESULT:
                    if (tx_fire)
                        res_idx <= res_idx + 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_test_engine.sv
// Directed bench for mem_test_engine with access and response scoreboards.
// Honors MEM_TEST_FIRST_FAIL_ADDR_EN for the CHECK result length.
module tb_mem_test_engine;
    import mem_test_engine_pkg::*;

    localparam int NB  = 20;
    localparam int BAW = 9;

    typedef struct packed {
        logic [NB-1:0]  cs;
        logic [BAW-1:0] addr;
        logic           we;
        logic [7:0]     wdata;
    } acc_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;

    acc_t       exp_acc[$];
    logic [7:0] exp_tx[$];
    logic [7:0] shadow [int];
    logic [7:0] mem [NB][512];
    int n_chk  = 0;
    int n_fail = 0;

    mem_test_engine_if #(.NUM_BANKS(NB), .BANK_ADDR_W(BAW)) bus();

    mem_test_engine #(
        .NUM_BANKS(NB), .BANK_ADDR_W(BAW), .ADDR_W(16), .DATA_W(8)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .o_busy (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: rdata is junk unless a read was issued last cycle.
    always @(posedge clk) begin
        bus.mem_rdata <= 8'hEE;
        for (int b = 0; b < NB; b++)
            if (bus.mem_cs[b]) begin
                if (bus.mem_we)
                    mem[b][bus.mem_addr] <= bus.mem_wdata;
                else
                    bus.mem_rdata <= mem[b][bus.mem_addr];
            end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        acc_t e;
        if (rst_n) begin
            if (bus.mem_cs != '0) begin
                if (exp_acc.size() == 0) begin
                    check("acc_extra", 0, 1);
                end else begin
                    e = exp_acc.pop_front();
                    check("acc_cs", 32'(bus.mem_cs), 32'(e.cs));
                    check("acc_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("acc_we", 32'(bus.mem_we), 32'(e.we));
                    if (e.we)
                        check("acc_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0)
                    check("tx_extra", 32'(exp_tx.size()), 1);
                else
                    check("tx_byte", 32'(bus.tx_byte), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic in_rng(input logic [15:0] a);
        return int'(a >> 9) < NB;
    endfunction

    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (!in_rng(a) || !shadow.exists(int'(a)))
            return 8'h00;
        return shadow[int'(a)];
    endfunction

    task automatic push_acc(input logic [15:0] a, input logic we,
                            input logic [7:0] d);
        acc_t e;
        if (in_rng(a)) begin
            e.cs = '0;
            e.cs[int'(a >> 9)] = 1'b1;
            e.addr  = a[8:0];
            e.we    = we;
            e.wdata = d;
            exp_acc.push_back(e);
        end
    endtask

    task automatic header(input logic [7:0] op, input logic [15:0] a,
                          input logic [7:0] len);
        bus.spi_cs_n = 1'b0;
        send(op);
        send(a[15:8]);
        send(a[7:0]);
        send(len);
    endtask

    task automatic finish_txn(input string tag);
        int k = 0;
        while ((exp_acc.size() + exp_tx.size()) != 0 && k < 2000) begin
            tick();
            k++;
        end
        check({tag, "_pending"}, 32'(exp_acc.size() + exp_tx.size()), 0);
        tick(2);
        check({tag, "_drain_busy"}, 32'(busy), 1);
        bus.spi_cs_n = 1'b1;
        tick();
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic do_fill(input logic [15:0] a, input logic [7:0] len,
                           input logic [7:0] p);
        for (int i = 0; i <= int'(len); i++) begin
            push_acc(a + 16'(i), 1'b1, p);
            if (in_rng(a + 16'(i)))
                shadow[int'(a + 16'(i))] = p;
        end
        header(OP_FILL, a, len);
        send(p);
        finish_txn("fill");
    endtask

    task automatic start_read(input logic [15:0] a, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            push_acc(a + 16'(i), 1'b0, 8'h00);
            exp_tx.push_back(model_rd(a + 16'(i)));
        end
        header(OP_READ, a, len);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] len);
        start_read(a, len);
        check("rd_lat0", 32'(bus.tx_valid), 0);
        tick();
        check("rd_lat1", 32'(bus.tx_valid), 0);
        tick();
        check("rd_lat2", 32'(bus.tx_valid), 1);
        finish_txn("read");
    endtask

    task automatic start_check(input logic [15:0] a, input logic [7:0] len,
                               input logic [7:0] p);
        int          errs = 0;
        logic [15:0] ff   = NO_FAIL_ADDR;
        for (int i = 0; i <= int'(len); i++) begin
            push_acc(a + 16'(i), 1'b0, 8'h00);
            if (model_rd(a + 16'(i)) != p) begin
                if (errs == 0)
                    ff = a + 16'(i);
                errs++;
            end
        end
        exp_tx.push_back(8'(errs >> 8));
        exp_tx.push_back(8'(errs));
`ifdef MEM_TEST_FIRST_FAIL_ADDR_EN
        exp_tx.push_back(ff[15:8]);
        exp_tx.push_back(ff[7:0]);
`endif
        header(OP_CHECK, a, len);
        send(p);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check({tag, "_tx_byte"}, 32'(bus.tx_byte), 0);
        check({tag, "_cs"}, 32'(bus.mem_cs), 0);
        check({tag, "_we"}, 32'(bus.mem_we), 0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        logic [7:0] held;
        int         k;
        bus.spi_cs_n = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        bus.tx_ready = 1'b1;
        #3 rst_n = 1'b0;
        tick(2);
        check_quiet("reset");
        rst_n = 1'b1;
        tick(2);

        do_fill(16'h0000, 8'd3, 8'hA5);
        do_read(16'h0000, 8'd3);

        do_fill(16'h01FF, 8'd1, 8'h3C);
        do_read(16'h01FF, 8'd1);

        do_read(16'h2800, 8'd0);

        do_fill(16'h0000, 8'd15, 8'h5A);
        do_fill(16'h0005, 8'd0, 8'h00);
        do_fill(16'h0009, 8'd0, 8'h00);
        start_check(16'h0000, 8'd15, 8'h5A);
        finish_txn("check");

        do_read(16'hFFFF, 8'd1);

        for (int i = 0; i < 8; i++)
            do_fill(16'h0400 + 16'(i), 8'd0, 8'(i * 17 + 3));
        start_read(16'h0400, 8'd7);
        k = 0;
        while (exp_tx.size() > 5 && k < 200) begin
            tick();
            k++;
        end
        check("bp_reach", 32'(exp_tx.size()), 5);
        bus.tx_ready = 1'b0;
        tick(2);
        held = bus.tx_byte;
        check("bp_next_byte", 32'(held), 32'(exp_tx[0]));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.tx_valid), 1);
            check("bp_stable", 32'(bus.tx_byte), 32'(held));
            tick();
        end
        bus.tx_ready = 1'b1;
        finish_txn("bp");

        for (int i = 0; i < 3; i++)
            push_acc(16'h0600 + 16'(i), 1'b1, 8'h77);
        header(OP_FILL, 16'h0600, 8'd9);
        send(8'h77);
        tick(3);
        bus.spi_cs_n = 1'b1;
        tick();
        check("abort_idle", 32'(busy), 0);
        tick(3);
        check("abort_writes", 32'(exp_acc.size()), 0);
        for (int i = 0; i < 3; i++)
            check("abort_mem", 32'(mem[3][i]), 32'h77);

        bus.spi_cs_n = 1'b0;
        send(8'h7E);
        check("badop_drain", 32'(busy), 1);
        send(8'h01);
        send(8'h00);
        tick(4);
        check("badop_still", 32'(busy), 1);
        bus.spi_cs_n = 1'b1;
        tick();
        check("badop_idle", 32'(busy), 0);

        start_check(16'h0000, 8'd15, 8'h5A);
        tick(6);
        #2 rst_n = 1'b0;
        #1 check_quiet("midrst");
        exp_acc.delete();
        exp_tx.delete();
        tick();
        bus.spi_cs_n = 1'b1;
        rst_n = 1'b1;
        tick(2);

        do_read(16'h0005, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
